load_unit: RTL and testbench



---
 rtl/load_unit.sv | 130 +++++++++++++
 tb/tb_load_unit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/load_unit.sv
// Load unit: extracts, aligns and sign/zero-extends LB/LH/LW/LBU/LHU data from the data memory.
// Define LOAD_WRAP_COMPAT_EN to wrap straddling loads within one word instead of splitting them.
module load_unit #(
    parameter int unsigned MP_WIDTH = 32
) (
    input  logic                iclk,
    input  logic                irst_n,
    input  logic                ivalid,
    output logic                oready,
    input  logic [MP_WIDTH-1:0] iaddr,
    input  logic [2:0]          ifunct3,
    output logic [MP_WIDTH-1:0] omem_pos,
    input  logic [MP_WIDTH-1:0] imem_rdata,
    output logic [MP_WIDTH-1:0] ordata,
    output logic                ordata_valid,
    output logic                omisaligned,
    output logic                oerr
);

    typedef enum logic [0:0] {StIdle, StSecond} state_e;

    state_e              state_q;
    logic [MP_WIDTH-1:0] lat_addr_q;
    logic [2:0]          lat_funct3_q;
    logic [MP_WIDTH-1:0] lat_word_q;

    logic                legal;
    logic                split;
    logic [1:0]          offset;
    logic [2:0]          lane;
    logic [2:0]          split_lane;
    logic [MP_WIDTH-1:0] single_raw;
    logic [MP_WIDTH-1:0] split_raw;
    logic [MP_WIDTH-3:0] next_word;

    function automatic logic [MP_WIDTH-1:0] extend(input logic [MP_WIDTH-1:0] raw,
                                                   input logic [2:0]          funct3);
        logic [MP_WIDTH-1:0] res;
        case (funct3)
            3'b000:  res = {{(MP_WIDTH-8){raw[7]}}, raw[7:0]};
            3'b001:  res = {{(MP_WIDTH-16){raw[15]}}, raw[15:0]};
            3'b100:  res = {{(MP_WIDTH-8){1'b0}}, raw[7:0]};
            3'b101:  res = {{(MP_WIDTH-16){1'b0}}, raw[15:0]};
            default: res = raw;
        endcase
        return res;
    endfunction

    always_comb begin
        legal = 1'b0;
        case (ifunct3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal = 1'b1;
            default:                                legal = 1'b0;
        endcase
    end

`ifdef LOAD_WRAP_COMPAT_EN
    // Word loads ignore the low address bits; halves rotate within the same word.
    assign offset = (ifunct3[1:0] == 2'b10) ? 2'b00 : iaddr[1:0];
    assign split  = 1'b0;
`else
    assign offset = iaddr[1:0];
    assign split  = legal && ((ifunct3[1:0] == 2'b01) ? (iaddr[1:0] == 2'b11)
                                                     : ((ifunct3[1:0] == 2'b10) &&
                                                        (iaddr[1:0] != 2'b00)));
`endif

    // Byte i of the result comes from lane offset+i; lanes 4..7 belong to the following word.
    always_comb begin
        lane       = 3'b000;
        split_lane = 3'b000;
        single_raw = '0;
        split_raw  = '0;
        for (int i = 0; i < 4; i++) begin
            lane       = {1'b0, offset} + 3'(i);
            split_lane = {1'b0, lat_addr_q[1:0]} + 3'(i);
            single_raw[8*i +: 8] = imem_rdata[{lane[1:0], 3'b000} +: 8];
            split_raw[8*i +: 8]  = split_lane[2] ? imem_rdata[{split_lane[1:0], 3'b000} +: 8]
                                                 : lat_word_q[{split_lane[1:0], 3'b000} +: 8];
        end
    end

    assign next_word = lat_addr_q[MP_WIDTH-1:2] + (MP_WIDTH-2)'(1);
    assign oready    = (state_q == StIdle);
    assign omem_pos  = oready ? iaddr : {next_word, 2'b00};

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            state_q      <= StIdle;
            lat_addr_q   <= '0;
            lat_funct3_q <= 3'b000;
            lat_word_q   <= '0;
            ordata       <= '0;
            ordata_valid <= 1'b0;
            omisaligned  <= 1'b0;
            oerr         <= 1'b0;
        end else begin
            ordata_valid <= 1'b0;
            omisaligned  <= 1'b0;
            oerr         <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (ivalid) begin
                        if (!legal) begin
                            ordata       <= '0;
                            ordata_valid <= 1'b1;
                            oerr         <= 1'b1;
                        end else if (split) begin
                            lat_addr_q   <= iaddr;
                            lat_funct3_q <= ifunct3;
                            lat_word_q   <= imem_rdata;
                            state_q      <= StSecond;
                        end else begin
                            ordata       <= extend(single_raw, ifunct3);
                            ordata_valid <= 1'b1;
                        end
                    end
                end
                StSecond: begin
                    ordata       <= extend(split_raw, lat_funct3_q);
                    ordata_valid <= 1'b1;
                    omisaligned  <= 1'b1;
                    state_q      <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_load_unit.sv
// Self-checking bench for load_unit: byte-level memory model plus literal expectations.
`timescale 1ns/1ps
module tb_load_unit;

    logic        iclk = 1'b0;
    logic        irst_n = 1'b0;
    logic        ivalid = 1'b0;
    logic        oready;
    logic [31:0] iaddr = 32'h0;
    logic [2:0]  ifunct3 = 3'b000;
    logic [31:0] omem_pos;
    logic [31:0] imem_rdata;
    logic [31:0] ordata;
    logic        ordata_valid;
    logic        omisaligned;
    logic        oerr;

    load_unit #(.MP_WIDTH(32)) dut (
        .iclk         (iclk),
        .irst_n       (irst_n),
        .ivalid       (ivalid),
        .oready       (oready),
        .iaddr        (iaddr),
        .ifunct3      (ifunct3),
        .omem_pos     (omem_pos),
        .imem_rdata   (imem_rdata),
        .ordata       (ordata),
        .ordata_valid (ordata_valid),
        .omisaligned  (omisaligned),
        .oerr         (oerr)
    );

    always #5 iclk = ~iclk;

    function automatic logic [31:0] word_at(input logic [29:0] idx);
        if (idx == 30'd0) return 32'h8877_6655;
        if (idx == 30'd1) return 32'h4433_2211;
        return {16'hC0DE, idx[15:0]};
    endfunction

    assign imem_rdata = word_at(omem_pos[31:2]);

    function automatic logic [7:0] byte_at(input logic [31:0] a);
        logic [31:0] w;
        w = word_at(a[31:2]);
        return w[{a[1:0], 3'b000} +: 8];
    endfunction

    // Expected result of a load, built byte by byte from memory.
    function automatic void model(input logic [31:0] a, input logic [2:0] f,
                                  output logic [31:0] val, output logic err,
                                  output logic split);
        int size;
        logic [31:0] raw;
        err = 1'b0; split = 1'b0; val = 32'h0; raw = 32'h0; size = 0;
        case (f)
            3'b000, 3'b100: size = 1;
            3'b001, 3'b101: size = 2;
            3'b010:         size = 4;
            default: begin err = 1'b1; return; end
        endcase
`ifdef LOAD_WRAP_COMPAT_EN
        if (size == 4) raw = word_at(a[31:2]);
        else for (int i = 0; i < size; i++)
            raw[8*i +: 8] = byte_at({a[31:2], 2'(a[1:0] + 2'(i))});
`else
        for (int i = 0; i < size; i++) raw[8*i +: 8] = byte_at(a + 32'(i));
        split = (int'(a[1:0]) + size) > 4;
`endif
        if (size == 1)      val = f[2] ? {24'h0, raw[7:0]}  : 32'($signed(raw[7:0]));
        else if (size == 2) val = f[2] ? {16'h0, raw[15:0]} : 32'($signed(raw[15:0]));
        else                val = raw;
    endfunction

    typedef struct {
        int          due;
        logic [31:0] val;
        logic        mis;
        logic        err;
        logic        has_lit;
        logic [31:0] lit;
    } exp_t;

    typedef struct {
        logic        v;
        logic [31:0] a;
        logic [2:0]  f;
        logic [31:0] lit;
    } vec_t;

    exp_t        q[$];
    vec_t        tbl[$];
    int          vectors = 0;
    int          errors = 0;
    int          cyc = 0;
    int          busy_until = 0;
    logic [31:0] held = 32'h0;
    logic [31:0] sec_pos = 32'h0;
    logic        accepted = 1'b0;
    logic        cur_has_lit = 1'b0;
    logic [31:0] cur_lit = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic add(input logic v, input logic [31:0] a, input logic [2:0] f,
                       input logic [31:0] lit_split, input logic [31:0] lit_wrap);
        vec_t t;
        t.v = v; t.a = a; t.f = f;
`ifdef LOAD_WRAP_COMPAT_EN
        t.lit = lit_wrap;
`else
        t.lit = lit_split;
`endif
        tbl.push_back(t);
    endtask

    always @(posedge iclk) cyc <= cyc + 1;

    always @(negedge iclk) begin : compare
        exp_t        e;
        logic [31:0] v;
        logic        er, sp, exp_ready;
        if (!irst_n) begin
            q.delete();
            held = 32'h0;
            busy_until = 0;
            accepted = 1'b0;
            chk("reset_ordata", ordata, 32'h0);
            chk("reset_pulses", {29'h0, ordata_valid, omisaligned, oerr}, 32'h0);
            chk("reset_ready", {31'h0, oready}, 32'h1);
        end else begin
            if (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                chk("valid", {31'h0, ordata_valid}, 32'h1);
                chk("ordata_model", ordata, e.val);
                chk("misaligned", {31'h0, omisaligned}, {31'h0, e.mis});
                chk("err", {31'h0, oerr}, {31'h0, e.err});
                if (e.has_lit) chk("ordata_literal", ordata, e.lit);
                held = e.val;
            end else begin
                chk("idle_pulses", {29'h0, ordata_valid, omisaligned, oerr}, 32'h0);
                chk("ordata_held", ordata, held);
            end
            exp_ready = (cyc >= busy_until);
            chk("ready", {31'h0, oready}, {31'h0, exp_ready});
            chk("mem_pos", omem_pos, exp_ready ? iaddr : sec_pos);
            accepted = ivalid && exp_ready;
            if (accepted) begin
                model(iaddr, ifunct3, v, er, sp);
                e.due = cyc + (sp ? 2 : 1);
                e.val = v; e.mis = sp; e.err = er;
                e.has_lit = cur_has_lit; e.lit = cur_lit;
                q.push_back(e);
                if (sp) begin
                    busy_until = cyc + 2;
                    sec_pos = {iaddr[31:2], 2'b00} + 32'd4;
                end
            end
        end
    end

    initial begin
        logic got;
        add(1'b0, 32'h0, 3'b000, 32'h0, 32'h0);
        add(1'b1, 32'h3, 3'b000, 32'hFFFF_FF88, 32'hFFFF_FF88);
        add(1'b1, 32'h3, 3'b100, 32'h0000_0088, 32'h0000_0088);
        add(1'b1, 32'h2, 3'b001, 32'hFFFF_8877, 32'hFFFF_8877);
        add(1'b1, 32'h1, 3'b101, 32'h0000_7766, 32'h0000_7766);
        add(1'b0, 32'h0, 3'b000, 32'h0, 32'h0);
        add(1'b1, 32'h3, 3'b001, 32'h0000_1188, 32'h0000_5588);
        add(1'b1, 32'h1, 3'b010, 32'h1188_7766, 32'h8877_6655);
        add(1'b1, 32'h0, 3'b011, 32'h0000_0000, 32'h0000_0000);
        add(1'b1, 32'h4, 3'b010, 32'h4433_2211, 32'h4433_2211);
        add(1'b0, 32'h0, 3'b000, 32'h0, 32'h0);
        add(1'b1, 32'hFFFF_FFFD, 3'b010, 32'h55C0_DEFF, 32'hC0DE_FFFF);
        add(1'b1, 32'h3, 3'b010, 32'h3322_1188, 32'h8877_6655);
        add(1'b1, 32'h2, 3'b010, 32'h2211_8877, 32'h8877_6655);
        add(1'b1, 32'h5, 3'b110, 32'h0000_0000, 32'h0000_0000);
        add(1'b1, 32'h6, 3'b001, 32'h0000_4433, 32'h0000_4433);
        add(1'b1, 32'h0, 3'b000, 32'h0000_0055, 32'h0000_0055);
        add(1'b1, 32'h0, 3'b001, 32'h0000_6655, 32'h0000_6655);
        add(1'b1, 32'h7, 3'b101, 32'h0000_0244, 32'h0000_1144);
        add(1'b1, 32'h0, 3'b111, 32'h0000_0000, 32'h0000_0000);
        add(1'b1, 32'h5, 3'b000, 32'h0000_0022, 32'h0000_0022);
        add(1'b0, 32'h0, 3'b000, 32'h0, 32'h0);

        repeat (3) @(posedge iclk);
        #2 irst_n = 1'b1;

        foreach (tbl[i]) begin
            @(posedge iclk); #1;
            iaddr = tbl[i].a; ifunct3 = tbl[i].f; ivalid = tbl[i].v;
            cur_lit = tbl[i].lit; cur_has_lit = tbl[i].v;
            if (tbl[i].v) begin
                got = 1'b0;
                for (int k = 0; k < 8 && !got; k++) begin
                    @(posedge iclk); #1;
                    got = accepted;
                end
                if (!got) begin
                    vectors++; errors++;
                    $display("FAIL accept_timeout: vector %0d never accepted", i);
                end
                ivalid = 1'b0;
            end
        end

        // Abandon a split load with an asynchronous reset mid-flight.
        repeat (3) @(posedge iclk);
        #1;
        iaddr = 32'h2; ifunct3 = 3'b010; ivalid = 1'b1; cur_has_lit = 1'b0;
        @(posedge iclk); #1;
        ivalid = 1'b0;
        vectors++;
        if (!accepted) begin
            errors++;
            $display("FAIL reset_accept: got 0 expected 1");
        end
        #2 irst_n = 1'b0;
        @(posedge iclk); #2 irst_n = 1'b1;
        repeat (5) @(posedge iclk);
        #1;
        chk("drain", q.size(), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
